// File: rtl/xintf_tx_scheduler.sv
// XINTF DPBRAM write-port scheduler: round-robin arbitration of three sources,
// 32-to-2x16 serialisation and the o_w_valid/i_w_ready DSP handshake with a watchdog.
module xintf_tx_scheduler #(
    parameter int TIMEOUT_CYC = 20000,
    parameter int ADDR_W      = 9
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [2:0]        i_req,
    input  logic [ADDR_W-1:0] i_addr_0,
    input  logic [ADDR_W-1:0] i_addr_1,
    input  logic [ADDR_W-1:0] i_addr_2,
    input  logic [31:0]       i_data_0,
    input  logic [31:0]       i_data_1,
    input  logic [31:0]       i_data_2,
    output logic [2:0]        o_ack,
    output logic              o_busy,
    output logic [ADDR_W-1:0] o_xintf_addr,
    output logic              o_xintf_ce,
    output logic [15:0]       o_xintf_din,
    output logic              o_w_valid,
    input  logic              i_w_ready,
    input  logic              i_err_clr,
    output logic              o_timeout_err,
    output logic [1:0]        o_last_grant
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_LO,
        S_WR_HI,
        S_NOTIFY,
        S_RELEASE,
        S_DONE,
        S_ABORT
    } state_t;

    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [WD_W-1:0] WD_MAX  = '1;

    state_t state_q, state_d;

    logic [1:0]        ptr_q;
    logic [1:0]        grant_q;
    logic [ADDR_W-1:0] base_q;
    logic [31:0]       data_q;
    logic [WD_W-1:0]   wd_q;
    logic              rdy_m, rdy_s;
    logic              err_q;
    logic [1:0]        last_q;
    logic [15:0]       din_q;
    logic [ADDR_W-1:0] addr_q;

    logic              gnt_hit;
    logic [1:0]        gnt_idx;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_data;
    logic              wd_expired;
    logic              wd_enter;

    function automatic logic [1:0] rr_idx(input logic [1:0] p, input logic [1:0] off);
        logic [2:0] s;
        s = {1'b0, p} + {1'b0, off};
        return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
    endfunction

    // Scan from the farthest offset down so the nearest set bit after ptr wins.
    always_comb begin
        gnt_hit = 1'b0;
        gnt_idx = ptr_q;
        for (int i = 2; i >= 0; i--) begin
            if (i_req[rr_idx(ptr_q, 2'(i))]) begin
                gnt_hit = 1'b1;
                gnt_idx = rr_idx(ptr_q, 2'(i));
            end
        end
    end

    always_comb begin
        sel_addr = i_addr_0;
        sel_data = i_data_0;
        unique case (gnt_idx)
            2'd1: begin
                sel_addr = i_addr_1;
                sel_data = i_data_1;
            end
            2'd2: begin
                sel_addr = i_addr_2;
                sel_data = i_data_2;
            end
            default: begin
                sel_addr = i_addr_0;
                sel_data = i_data_0;
            end
        endcase
    end

    assign wd_expired = (wd_q >= WD_LAST);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (gnt_hit) state_d = S_WR_LO;
            S_WR_LO:   state_d = S_WR_HI;
            S_WR_HI:   state_d = S_NOTIFY;
            S_NOTIFY: begin
                if (rdy_s)           state_d = S_RELEASE;
                else if (wd_expired) state_d = S_ABORT;
            end
            S_RELEASE: begin
                if (!rdy_s)          state_d = S_DONE;
                else if (wd_expired) state_d = S_ABORT;
            end
            S_DONE:    state_d = S_IDLE;
            S_ABORT:   state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    assign wd_enter = (state_d != state_q)
                    && ((state_d == S_NOTIFY) || (state_d == S_RELEASE));

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= S_IDLE;
            ptr_q   <= 2'd0;
            grant_q <= 2'd0;
            base_q  <= '0;
            data_q  <= '0;
            last_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && gnt_hit) begin
                grant_q <= gnt_idx;
                last_q  <= gnt_idx;
                ptr_q   <= rr_idx(gnt_idx, 2'd1);
                base_q  <= {sel_addr[ADDR_W-1:1], 1'b0};
                data_q  <= sel_data;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            rdy_m <= 1'b0;
            rdy_s <= 1'b0;
        end else begin
            rdy_m <= i_w_ready;
            rdy_s <= rdy_m;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wd_q <= '0;
        end else if (wd_enter) begin
            wd_q <= '0;
        end else if (state_q == S_NOTIFY || state_q == S_RELEASE) begin
            if (wd_q != WD_MAX) wd_q <= wd_q + 1'b1;
        end
    end

    // Abort sets the flag even if a clear arrives in the same cycle.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            err_q <= 1'b0;
        end else if (state_q == S_ABORT) begin
            err_q <= 1'b1;
        end else if (i_err_clr) begin
            err_q <= 1'b0;
        end
    end

    always_comb begin
        o_xintf_ce   = 1'b0;
        o_xintf_din  = din_q;
        o_xintf_addr = addr_q;
        unique case (state_q)
            S_WR_LO: begin
                o_xintf_ce   = 1'b1;
                o_xintf_din  = data_q[15:0];
                o_xintf_addr = base_q;
            end
            S_WR_HI: begin
                o_xintf_ce   = 1'b1;
                o_xintf_din  = data_q[31:16];
                o_xintf_addr = base_q | ADDR_W'(1);
            end
            default: begin
                o_xintf_ce   = 1'b0;
                o_xintf_din  = din_q;
                o_xintf_addr = addr_q;
            end
        endcase
    end

    // Bus holds the last written word outside the write states.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            din_q  <= '0;
            addr_q <= '0;
        end else begin
            din_q  <= o_xintf_din;
            addr_q <= o_xintf_addr;
        end
    end

    assign o_busy        = (state_q != S_IDLE);
    assign o_w_valid     = (state_q == S_NOTIFY);
    assign o_ack         = (state_q == S_DONE || state_q == S_ABORT)
                         ? (3'b001 << grant_q) : 3'b000;
    assign o_timeout_err = err_q;
    assign o_last_grant  = last_q;

endmodule

// File: tb/tb_xintf_tx_scheduler.sv
// Scoreboard bench for xintf_tx_scheduler: expected DPBRAM writes and acks
// are queued at stimulus time and popped as the DUT produces them.
module tb_xintf_tx_scheduler;

    localparam int ADDR_W = 9;
    localparam int TMO    = 16;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [15:0]       d;
    } wr_t;

    typedef struct {
        logic [2:0] ack;
        logic [1:0] g;
    } ack_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [ADDR_W-1:0] addr [3];
    logic [31:0]       data [3];
    logic [2:0]        ack;
    logic              busy;
    logic [ADDR_W-1:0] x_addr;
    logic              x_ce;
    logic [15:0]       x_din;
    logic              w_valid;
    logic              w_ready = 1'b0;
    logic              err_clr = 1'b0;
    logic              tmo_err;
    logic [1:0]        last_grant;
    logic              dsp_en = 1'b1;

    int  want [3];
    int  acked [3];
    wire [2:0] req = {want[2] > acked[2], want[1] > acked[1], want[0] > acked[0]};

    wr_t  wq[$];
    ack_t aq[$];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    xintf_tx_scheduler #(
        .TIMEOUT_CYC(TMO),
        .ADDR_W(ADDR_W)
    ) dut (
        .i_clk(clk),
        .i_rst(rst_n),
        .i_req(req),
        .i_addr_0(addr[0]),
        .i_addr_1(addr[1]),
        .i_addr_2(addr[2]),
        .i_data_0(data[0]),
        .i_data_1(data[1]),
        .i_data_2(data[2]),
        .o_ack(ack),
        .o_busy(busy),
        .o_xintf_addr(x_addr),
        .o_xintf_ce(x_ce),
        .o_xintf_din(x_din),
        .o_w_valid(w_valid),
        .i_w_ready(w_ready),
        .i_err_clr(err_clr),
        .o_timeout_err(tmo_err),
        .o_last_grant(last_grant)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_item(input int g, input bit with_ack);
        wr_t  w;
        ack_t k;
        logic [ADDR_W-1:0] base;
        base = addr[g] & ~ADDR_W'(1);
        w.a = base;
        w.d = data[g][15:0];
        wq.push_back(w);
        w.a = base + ADDR_W'(1);
        w.d = data[g][31:16];
        wq.push_back(w);
        if (with_ack) begin
            k.ack = 3'(1 << g);
            k.g   = 2'(g);
            aq.push_back(k);
        end
    endtask

    task automatic wait_idle(input string tag);
        int cyc = 0;
        while ((wq.size() != 0 || aq.size() != 0 || busy || req != 0)
               && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        repeat (2) @(negedge clk);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_wq_left"}, wq.size(), 0);
        check({tag, "_aq_left"}, aq.size(), 0);
    endtask

    task automatic wait_valid(input string tag);
        int cyc = 0;
        while (!w_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_valid_seen"}, 32'(w_valid), 1);
    endtask

    task automatic wait_ack(input string tag);
        int cyc = 0;
        while (ack == 3'b000 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_ack_seen"}, 32'(ack != 3'b000), 1);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (x_ce) begin
                if (wq.size() == 0) begin
                    check("wr_unexpected", 32'(x_ce), 0);
                end else begin
                    wr_t e;
                    e = wq.pop_front();
                    check("wr_addr", 32'(x_addr), 32'(e.a));
                    check("wr_din", 32'(x_din), 32'(e.d));
                end
            end
            if (ack != 3'b000) begin
                if (aq.size() == 0) begin
                    check("ack_unexpected", 32'(ack), 0);
                end else begin
                    ack_t k;
                    k = aq.pop_front();
                    check("ack", 32'(ack), 32'(k.ack));
                    check("last_grant", 32'(last_grant), 32'(k.g));
                end
                for (int i = 0; i < 3; i++)
                    if (ack[i]) acked[i]++;
            end
        end
    end

    // DSP: ready 5 cycles after valid, held 3 cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (dsp_en && w_valid && rst_n) begin
                repeat (5) @(negedge clk);
                w_ready = 1'b1;
                repeat (3) @(negedge clk);
                w_ready = 1'b0;
            end
        end
    end

    task automatic reset_checks(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_ack"}, 32'(ack), 0);
        check({tag, "_ce"}, 32'(x_ce), 0);
        check({tag, "_valid"}, 32'(w_valid), 0);
    endtask

    initial begin
        int vcnt;
        for (int i = 0; i < 3; i++) begin
            want[i]  = 0;
            acked[i] = 0;
            addr[i]  = '0;
            data[i]  = '0;
        end
        #2;
        reset_checks("rst");
        check("rst_err", 32'(tmo_err), 0);
        check("rst_last", 32'(last_grant), 0);
        check("rst_din", 32'(x_din), 0);
        check("rst_addr", 32'(x_addr), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        addr[0] = 9'h010;
        data[0] = 32'hA5A5_1234;
        push_item(0, 1);
        want[0]++;
        wait_idle("single");

        addr[1] = 9'h023;
        data[1] = 32'h0000_FFFF;
        push_item(1, 1);
        want[1]++;
        wait_idle("odd");

        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        addr[2] = 9'h1F4;
        data[2] = 32'hDEAD_BEEF;
        push_item(0, 1);
        push_item(1, 1);
        push_item(2, 1);
        want[0]++;
        want[1]++;
        want[2]++;
        wait_idle("fair3");

        push_item(0, 1);
        push_item(2, 1);
        push_item(0, 1);
        push_item(2, 1);
        want[0] += 2;
        want[2] += 2;
        wait_idle("fair02");

        dsp_en = 1'b0;
        push_item(0, 1);
        want[0]++;
        wait_valid("tmo1");
        vcnt = 0;
        while (w_valid && vcnt < 100) begin
            vcnt++;
            @(negedge clk);
        end
        check("tmo_valid_cycles", vcnt, TMO);
        @(negedge clk);
        check("tmo_err_set", 32'(tmo_err), 1);
        wait_idle("tmo1");
        repeat (5) @(negedge clk);
        check("tmo_err_sticky", 32'(tmo_err), 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("tmo_err_clr", 32'(tmo_err), 0);

        push_item(0, 1);
        want[0]++;
        wait_ack("tmo2");
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("tmo_set_wins", 32'(tmo_err), 1);
        wait_idle("tmo2");
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;

        push_item(0, 0);
        want[0]++;
        wait_valid("midrst");
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        reset_checks("midrst");
        check("midrst_wq", wq.size(), 0);
        acked[0] = want[0];
        dsp_en = 1'b1;
        addr[1] = 9'h041;
        data[1] = 32'h1357_2468;
        addr[2] = 9'h0A0;
        data[2] = 32'hCAFE_0001;
        push_item(1, 1);
        push_item(2, 1);
        want[1]++;
        want[2]++;
        @(negedge clk);
        rst_n = 1'b1;
        wait_idle("midrst");
        check("midrst_last", 32'(last_grant), 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/xintf_tx_scheduler.md
Name: xintf_tx_scheduler

Overview:
Arbitrates the single Zynq-to-DSP XINTF DPBRAM write port between three requesters: the waveform setpoint engine, the SFP slave setpoint path and AXI parameter updates. It serialises each granted 32-bit item into two 16-bit DPBRAM writes, then performs the o_w_valid / i_w_ready notification handshake with the DSP. A watchdog aborts hung handshakes. Sits between the register/waveform sources and the DPBRAM write port inside the MPS core.

Parameters:
TIMEOUT_CYC, 20000, cycles allowed for each DSP handshake phase before abort (100 us at 200 MHz)
ADDR_W, 9, DPBRAM address width

Ports:
i_clk  in  1  core clock
i_rst  in  1  asynchronous active-low reset
i_req  in  3  request per requester; bit0 = waveform, bit1 = SFP, bit2 = AXI
i_addr_0 / i_addr_1 / i_addr_2  in  ADDR_W each  word base address per requester; LSB ignored
i_data_0 / i_data_1 / i_data_2  in  32 each  payload per requester
o_ack  out  3  one-cycle pulse to the requester whose item completed or aborted
o_busy  out  1  high in any state other than IDLE
o_xintf_addr  out  ADDR_W  DPBRAM address
o_xintf_ce  out  1  DPBRAM chip enable (write strobe; we is tied high outside)
o_xintf_din  out  16  DPBRAM write data
o_w_valid  out  1  write-valid to DSP
i_w_ready  in  1  write-ready from DSP, asynchronous to i_clk
i_err_clr  in  1  clears o_timeout_err
o_timeout_err  out  1  sticky handshake-timeout flag
o_last_grant  out  2  index of the last granted requester (0..2)

Behaviour:
- Reset (async, i_rst=0):
  - all outputs 0; FSM to IDLE
  - round-robin pointer = 0, so requester 0 has top priority first
  - watchdog = 0; ready synchroniser flops = 0
- i_w_ready passes through a 2-flop synchroniser; all references below use the synchronised value (rdy_s).
- States:
  - IDLE: if any i_req bit is set, grant the first set bit searching from the pointer upward with wrap (ptr, ptr+1, ptr+2 mod 3).
    - latch that requester's address {addr[8:1], 0} and its data
    - set o_last_grant; pointer <= grant+1 mod 3; go to WR_LO
  - WR_LO (1 cycle): o_xintf_ce=1, o_xintf_addr=base, o_xintf_din=data[15:0] -> WR_HI
  - WR_HI (1 cycle): o_xintf_ce=1, o_xintf_addr=base|1, o_xintf_din=data[31:16] -> NOTIFY
  - NOTIFY: o_w_valid=1.
    - rdy_s=1 -> RELEASE
    - watchdog reaches TIMEOUT_CYC-1 -> ABORT
  - RELEASE: o_w_valid=0; wait for rdy_s=0.
    - rdy_s=0 -> DONE
    - timeout -> ABORT
  - DONE (1 cycle): o_ack[grant]=1 -> IDLE
  - ABORT (1 cycle): o_w_valid=0, o_timeout_err<=1, o_ack[grant]=1 -> IDLE
- Watchdog:
  - cleared on entry to NOTIFY and on entry to RELEASE
  - counts +1 per cycle while in those states; saturates, never wraps
- Latency: a request in IDLE reaches o_xintf_ce in the cycle after the grant. Best case is request to ack in 6 cycles plus DSP response and synchroniser delay.
- Minimum spacing: back-to-back items are separated by at least one IDLE cycle.
- Outputs in all other states: o_xintf_ce=0 and o_xintf_din holds its last value.
- Requests are level-sensitive and latched at grant.
  - A request deasserted after grant still completes.
  - New data on the bus after grant is ignored.
  - A requester keeps i_req high until it sees its o_ack, then drops i_req within 1 cycle; otherwise it is served again in its next round-robin turn.
- Simultaneous i_err_clr and timeout in the same cycle: set wins.
- rdy_s already high when NOTIFY is entered: advance to RELEASE in 1 cycle (a stale ready is accepted).
- Reset mid-transaction: the item is discarded, no ack is issued, o_w_valid drops immediately.

Test Plan:
- Single request: i_req=001, addr_0=0x010, data_0=0xA5A5_1234, DSP raises ready 5 cycles after valid and drops it 3 cycles later. Required: ce at 0x010 with din 0x1234, then 0x011 with 0xA5A5; o_w_valid high until rdy_s; o_ack=001 exactly once; o_busy low afterwards.
- Fairness: all three i_req held high for 3 items. Required grant order 0,1,2 (o_last_grant 0,1,2); with only 0 and 2 held, order alternates 0,2,0,2.
- Odd base address: addr_1=0x023, data_1=0x0000_FFFF. Required writes: 0x022←0xFFFF, then 0x023←0x0000.
- Timeout: TIMEOUT_CYC=16, i_w_ready held low. Required: o_w_valid high exactly 16 cycles; ABORT; o_ack pulse; o_timeout_err=1 until i_err_clr; i_err_clr asserted in the same cycle as a second timeout leaves it at 1.
- Reset mid-NOTIFY: drop i_rst while o_w_valid=1. Required: o_w_valid, o_busy, o_ack and o_xintf_ce are 0 asynchronously; after release, the pointer is 0 and a pending i_req=110 grants requester 1 first.
